// File: rtl/ram_if.sv
// ram_if -- bus bundle for the simple dual-port RAM.
//   wr_en    : write enable, sampled at the rising clock edge
//   wr_addr  : write address
//   data_in  : write data
//   rd_addr  : read address, sampled at the rising clock edge
//   data_out : registered read data, one cycle after rd_addr
// Modports:
//   master : the client that drives addresses and data, and receives data_out
//   slave  : the RAM itself
interface ram_if #(
  parameter int WIDTH     = 32,
  parameter int WORD_SIZE = 3
);
  logic                 wr_en;
  logic [WORD_SIZE-1:0] wr_addr;
  logic [WIDTH-1:0]     data_in;
  logic [WORD_SIZE-1:0] rd_addr;
  logic [WIDTH-1:0]     data_out;

  modport master (
    output wr_en,
    output wr_addr,
    output data_in,
    output rd_addr,
    input  data_out
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  data_in,
    input  rd_addr,
    output data_out
  );
endinterface

// File: rtl/ram.sv
// ram -- single-clock simple dual-port RAM (one write port, one read port)
// used as the CPU data/instruction store.
//   clk : sole clock, all state changes on its rising edge
//   rst : synchronous active-high reset; clears every word and the read register
//   bus : ram_if.slave (wr_en, wr_addr, data_in, rd_addr, data_out)
// Read latency is one cycle. A read and a write to the same address at the
// same edge return the newly written data (write-first).
module ram #(
  parameter int WIDTH     = 32,
  parameter int WORD_SIZE = 3
) (
  input  logic clk,
  input  logic rst,
  ram_if.slave bus
);

  localparam int DEPTH = 2 ** WORD_SIZE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_p1;
  logic             fwd_p0;

  // Stage p0: inputs sampled at the edge; detect same-address read/write.
  assign fwd_p0 = bus.wr_en && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_p1 <= '0;
    end else begin
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= bus.data_in;
      end
      // mem update is non-blocking, so the new word is forwarded directly.
      rd_data_p1 <= fwd_p0 ? bus.data_in : mem[bus.rd_addr];
    end
  end

  // Stage p1: registered read data.
  assign bus.data_out = rd_data_p1;

endmodule

// File: tb/tb_ram.sv
// tb_ram -- directed self-checking bench for the ram block.
module tb_ram;

  localparam int WIDTH     = 32;
  localparam int WORD_SIZE = 3;
  localparam int DEPTH     = 2 ** WORD_SIZE;

  logic clk;
  logic rst;

  ram_if #(.WIDTH(WIDTH), .WORD_SIZE(WORD_SIZE)) bus ();

  ram #(.WIDTH(WIDTH), .WORD_SIZE(WORD_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive stimulus on the falling edge, then let one rising edge act on it
  // and sample the output just after.
  task automatic drive(input logic r, input logic we, input int wa,
                       input logic [WIDTH-1:0] wd, input int ra);
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_addr = WORD_SIZE'(wa);
    bus.data_in = wd;
    bus.rd_addr = WORD_SIZE'(ra);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] fill_vals [DEPTH];
  logic [WIDTH-1:0] held;

  initial begin
    fill_vals = '{32'd88, 32'd77, 32'd66, 32'd55, 32'd44, 32'd33, 32'd22, 32'd11};

    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.data_in = '0;
    bus.rd_addr = '0;

    // Reset held for two edges.
    edge_step();
    edge_step();
    check("reset_data_out", bus.data_out, '0);

    // Every word reads zero after reset.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 0, '0, i);
      edge_step();
      check($sformatf("reset_rd%0d", i), bus.data_out, '0);
    end

    // Fill 88..11 into addresses 0..7.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, i, fill_vals[i], 0);
      edge_step();
    end

    // Readback.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 0, '0, i);
      edge_step();
      check($sformatf("fill_rd%0d", i), bus.data_out, fill_vals[i]);
    end

    // No combinational path: changing rd_addr between edges leaves data_out.
    held = bus.data_out;
    drive(1'b0, 1'b0, 0, '0, 2);
    #1;
    check("hold_no_comb", bus.data_out, 32'd11);

    // Write disabled: address 3 keeps 55.
    drive(1'b0, 1'b0, 3, 32'd999, 3);
    edge_step();
    check("wr_disabled_rd3", bus.data_out, 32'd55);

    // Same-address collision forwards the new data.
    drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 5);
    edge_step();
    check("same_addr_fwd", bus.data_out, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 0, '0, 5);
    edge_step();
    check("same_addr_stored", bus.data_out, 32'hDEADBEEF);

    // Different-address collision: read sees old neighbour contents.
    drive(1'b0, 1'b1, 2, 32'd123, 1);
    edge_step();
    check("diff_addr_rd1", bus.data_out, 32'd77);
    drive(1'b0, 1'b0, 0, '0, 2);
    edge_step();
    check("diff_addr_rd2", bus.data_out, 32'd123);

    // Mid-operation reset with a pending write that must be discarded.
    drive(1'b1, 1'b1, 0, 32'd5, 0);
    edge_step();
    check("mid_reset_data_out", bus.data_out, '0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, 0, '0, i);
      edge_step();
      check($sformatf("mid_reset_rd%0d", i), bus.data_out, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
